uart_tx_top: RTL and testbench

Configurable UART transmitter. It serialises one 7- or 8-bit character per frame: start bit, data LSB first, optional odd/even parity, then 1 or 2 stop bits. Bit rate is chosen from four clock-divider settings. It sits between a parallel producer and the serial line and reports busy/done status.

---
 rtl/uart_tx_top.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_top.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_top.sv
// uart_tx_top: configurable UART transmitter.
// Sends start bit, 7/8 data bits LSB first, optional odd/even parity and
// 1 or 2 stop bits. The bit period is one of four clock-divider settings.
//
// Handshake: send is a level request rather than a valid/ready pair. A frame
// is accepted on any baud tick seen in IDLE while send=1. All frame settings
// are captured at that moment. tx_active is the "busy" indication: it is high
// from the clock that enters START until the frame-end tick. tx_done pulses
// for one clock right after that tick. Holding send high produces back-to-back
// frames, each separated by one idle bit period.
module uart_tx_top #(
  parameter int DIV_00 = 1302,
  parameter int DIV_01 = 651,
  parameter int DIV_10 = 326,
  parameter int DIV_11 = 163
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       send,
  input  logic [1:0] baud_rate,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic       data_out,
  output logic       p_parity_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  localparam int MAX_A   = (DIV_00 > DIV_01) ? DIV_00 : DIV_01;
  localparam int MAX_B   = (DIV_10 > DIV_11) ? DIV_10 : DIV_11;
  localparam int DIV_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(DIV_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] div_m1;
  logic [1:0]    div_sel;
  logic          tick;

  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic [1:0]    lat_baud;
  logic [1:0]    lat_parity;
  logic          lat_stop;
  logic          lat_len;

  logic [7:0]    data_masked;
  logic          data_xor;
  logic          new_parity;
  logic          parity_en;
  logic [2:0]    last_bit;

  logic          load;
  logic          shift;
  logic          stop_adv;
  logic          finish;

  // Busy flag depends on state only, so the divider select never loops back
  // through the next-state logic.
  assign tx_active = (state != IDLE);
  assign state_dbg = state;

  // Divider select: frozen to the captured rate during a frame, live while idle.
  always_comb begin
    div_sel = tx_active ? lat_baud : baud_rate;
    case (div_sel)
      2'b00:   div_m1 = CW'(DIV_00 - 1);
      2'b01:   div_m1 = CW'(DIV_01 - 1);
      2'b10:   div_m1 = CW'(DIV_10 - 1);
      default: div_m1 = CW'(DIV_11 - 1);
    endcase
  end

  // ">=" lets a shrinking divider tick and wrap at once instead of overrunning.
  assign tick = (baud_cnt >= div_m1);

  // Free-running baud counter, 0..DIV-1.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
    end else if (tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Parity of the bits that will actually be sent (bit 7 dropped in 7-bit mode).
  always_comb begin
    data_masked = data_length ? data_in : {1'b0, data_in[6:0]};
    data_xor    = ^data_masked;
    case (parity_type)
      2'b01:   new_parity = ~data_xor;
      2'b10:   new_parity = data_xor;
      default: new_parity = 1'b0;
    endcase
  end

  assign parity_en = lat_parity[0] ^ lat_parity[1];
  assign last_bit  = lat_len ? 3'd7 : 3'd6;

  // FSM state register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, serial line value and datapath strobes; moves only on ticks.
  always_comb begin
    state_next = state;
    data_out   = 1'b1;
    load       = 1'b0;
    shift      = 1'b0;
    stop_adv   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (tick && send) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        data_out = 1'b0;
        if (tick) begin
          state_next = DATA;
        end
      end
      DATA: begin
        data_out = shift_reg[0];
        if (tick) begin
          shift = 1'b1;
          if (bit_cnt == last_bit) begin
            state_next = parity_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        data_out = p_parity_out;
        if (tick) begin
          state_next = STOP;
        end
      end
      STOP: begin
        data_out = 1'b1;
        if (tick) begin
          if (stop_cnt == lat_stop) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            stop_adv = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame datapath: capture settings at accept, shift data, count stop bits.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      lat_baud     <= '0;
      lat_parity   <= '0;
      lat_stop     <= 1'b0;
      lat_len      <= 1'b0;
      p_parity_out <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      tx_done <= finish;
      if (load) begin
        shift_reg    <= data_in;
        bit_cnt      <= '0;
        stop_cnt     <= 1'b0;
        lat_baud     <= baud_rate;
        lat_parity   <= parity_type;
        lat_stop     <= stop_bits;
        lat_len      <= data_length;
        p_parity_out <= new_parity;
      end
      if (shift) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (stop_adv) begin
        stop_cnt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: bench for uart_tx_top. Directed frame table, random frames
// against a string-based frame model, back-to-back gap and mid-frame reset.
module tb_uart_tx_top;

  logic       clock;
  logic       rst;
  logic       send;
  logic [1:0] baud_rate;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic       data_out;
  logic       p_parity_out;
  logic       tx_active;
  logic       tx_done;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_tx_top dut (
    .clock        (clock),
    .rst          (rst),
    .send         (send),
    .baud_rate    (baud_rate),
    .data_in      (data_in),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_out     (data_out),
    .p_parity_out (p_parity_out),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .state_dbg    (state_dbg)
  );

  // Clock and overall time guard.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Counts every clock during which tx_done is high.
  always @(posedge clock) begin
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'b00:   return 1302;
      2'b01:   return 651;
      2'b10:   return 326;
      default: return 163;
    endcase
  endfunction

  // Reference model: builds the serial frame as a string of '0'/'1'.
  function automatic string frame_model(input logic [7:0] d, input logic [1:0] par,
                                        input logic stop, input logic len,
                                        output logic p);
    string s;
    int ones;
    int nb;
    s = "0";
    ones = 0;
    nb = len ? 8 : 7;
    for (int i = 0; i < nb; i++) begin
      if (d[i]) begin
        s = {s, "1"};
        ones++;
      end else begin
        s = {s, "0"};
      end
    end
    p = 1'b0;
    if (par == 2'b01) p = (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (par == 2'b10) p = (ones % 2 == 1) ? 1'b1 : 1'b0;
    if (par == 2'b01 || par == 2'b10) s = {s, (p ? "1" : "0")};
    s = {s, "1"};
    if (stop) s = {s, "1"};
    return s;
  endfunction

  task automatic drive(input logic [1:0] b, input logic [7:0] d, input logic [1:0] par,
                       input logic stop, input logic len);
    baud_rate   = b;
    data_in     = d;
    parity_type = par;
    stop_bits   = stop;
    data_length = len;
  endtask

  // Waits for a start bit, then checks every bit at its first and last clock,
  // the frame-end pulse and the line state afterwards. Returns one clock
  // after the frame-end tick.
  task automatic check_frame(input string tag, input int div, input string pat,
                             input logic exp_par, input bit keep_send, input bit scramble);
    int waited;
    int n;
    int done0;
    logic eb;
    waited = 0;
    n = pat.len();
    while (data_out !== 1'b0 && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    if (data_out !== 1'b0) begin
      chk32({tag, "_start_timeout"}, waited, -1);
      return;
    end
    chk1({tag, "_active_start"}, tx_active, 1'b1);
    chk1({tag, "_parity_out"}, p_parity_out, exp_par);
    if (!keep_send) send = 1'b0;
    if (scramble) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    done0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      eb = (pat[i] == 8'h31) ? 1'b1 : 1'b0;
      chk1($sformatf("%s_bit%0d_first", tag, i), data_out, eb);
      repeat (div - 1) @(negedge clock);
      chk1($sformatf("%s_bit%0d_last", tag, i), data_out, eb);
      @(negedge clock);
    end
    chk1({tag, "_done_pulse"}, tx_done, 1'b1);
    chk1({tag, "_active_end"}, tx_active, 1'b0);
    chk1({tag, "_line_idle"}, data_out, 1'b1);
    chk1({tag, "_parity_hold"}, p_parity_out, exp_par);
    @(negedge clock);
    chk1({tag, "_done_drop"}, tx_done, 1'b0);
    chk32({tag, "_done_count"}, done_cnt - done0, 1);
  endtask

  typedef struct {
    logic [1:0] baud;
    logic [7:0] data;
    logic [1:0] par;
    logic       stop;
    logic       len;
    string      pat;
    logic       exp_par;
    bit         b2b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad;
    int gap;
    int done0;
    int waited;
    string pat;
    logic p;
    logic [1:0] b;
    logic [7:0] d;
    logic [1:0] par;
    logic st;
    logic ln;

    vecs[0] = '{2'b00, 8'h55, 2'b01, 1'b0, 1'b1, "01010101011",  1'b1, 1'b0};
    vecs[1] = '{2'b01, 8'h12, 2'b10, 1'b1, 1'b1, "001001000011", 1'b0, 1'b0};
    vecs[2] = '{2'b10, 8'hAF, 2'b00, 1'b0, 1'b0, "011110101",    1'b0, 1'b0};
    vecs[3] = '{2'b11, 8'hA3, 2'b11, 1'b1, 1'b0, "0110001011",   1'b0, 1'b1};

    // Reset and quiet idle.
    rst = 1'b0;
    send = 1'b0;
    drive(2'b00, 8'h00, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk1("rst_data_out", data_out, 1'b1);
    chk1("rst_active", tx_active, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_parity", p_parity_out, 1'b0);
    chk32("rst_state_idle", int'(state_dbg), 0);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (data_out !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    chk32("idle_quiet", bad, 0);
    chk32("idle_no_done", done_cnt, 0);

    // Directed frame table.
    for (int v = 0; v < 4; v++) begin
      drive(vecs[v].baud, vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].len);
      send = 1'b1;
      check_frame($sformatf("vec%0d", v), div_of(vecs[v].baud), vecs[v].pat,
                  vecs[v].exp_par, vecs[v].b2b, !vecs[v].b2b);
      if (vecs[v].b2b) begin
        gap = 1;
        while (data_out !== 1'b0 && gap < 4000) begin
          gap++;
          @(negedge clock);
        end
        chk32($sformatf("vec%0d_gap", v), gap, div_of(vecs[v].baud));
        check_frame($sformatf("vec%0d_second", v), div_of(vecs[v].baud), vecs[v].pat,
                    vecs[v].exp_par, 1'b0, 1'b1);
      end
    end

    // Random frames against the model.
    for (int r = 0; r < 6; r++) begin
      b   = 2'($urandom_range(2, 3));
      d   = 8'($urandom);
      par = 2'($urandom_range(0, 3));
      st  = 1'($urandom_range(0, 1));
      ln  = 1'($urandom_range(0, 1));
      pat = frame_model(d, par, st, ln, p);
      drive(b, d, par, st, ln);
      send = 1'b1;
      check_frame($sformatf("rnd%0d", r), div_of(b), pat, p, 1'b0, 1'b1);
    end

    // Mid-frame input changes, then reset mid-frame.
    drive(2'b11, 8'hC6, 2'b01, 1'b0, 1'b1);
    send = 1'b1;
    waited = 0;
    while (data_out !== 1'b0 && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    chk1("mid_start_seen", data_out, 1'b0);
    send = 1'b0;
    drive(2'b00, 8'h00, 2'b00, 1'b1, 1'b0);
    repeat (3 * 163 + 80) @(negedge clock);
    chk1("mid_bit3_unaffected", data_out, 1'b1);
    chk1("mid_active", tx_active, 1'b1);
    chk1("mid_parity_unaffected", p_parity_out, 1'b1);
    done0 = done_cnt;
    rst = 1'b0;
    #1;
    chk1("midrst_line_high", data_out, 1'b1);
    chk1("midrst_active", tx_active, 1'b0);
    chk1("midrst_done", tx_done, 1'b0);
    chk1("midrst_parity", p_parity_out, 1'b0);
    repeat (5) @(negedge clock);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * 163; i++) begin
      @(negedge clock);
      if (data_out !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    chk32("midrst_no_resume", bad, 0);
    chk32("midrst_no_done", done_cnt - done0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
